// File: rtl/stream_pack.sv
// Result-set packer: snapshots CORE_NUM per-core results and replays them as
// 64-bit beats (two cores per beat) under the stream controller's stream_v strobe.
//
// state  | meaning
// IDLE   | no result set held; waiting for res_valid
// LOADED | result set captured, no beat emitted yet
// STREAM | at least one beat emitted, more remain
module stream_pack #(
    parameter int CORE_NUM = 4,
    parameter int CORE_W   = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       res_valid,
    input  logic [CORE_NUM*CORE_W-1:0] res_data,
    input  logic                       stream_v,
    input  logic                       dst_ready,
    output logic                       get_fin,
    output logic [63:0]                dst_data,
    output logic                       busy,
    output logic [1:0]                 err
);

    localparam int BEATS = CORE_NUM / 2;
    localparam int CNT_W = $clog2(BEATS + 1);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] LOADED = 2'd1;
    localparam logic [1:0] STREAM = 2'd2;

    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    logic [1:0]                 state;
    logic [CNT_W-1:0]           beat_cnt;
    logic [CORE_NUM*CORE_W-1:0] snap;
    logic [31:0]                core32 [CORE_NUM];
    logic [63:0]                beat_word;
    logic                       capture;

    // Stalls reach this block only through stream_v; dst_ready is kept for the port map.
    logic unused_dst_ready;
    assign unused_dst_ready = dst_ready;

    for (genvar k = 0; k < CORE_NUM; k++) begin : g_core
        if (CORE_W >= 32) begin : g_trunc
            assign core32[k] = snap[k*CORE_W +: 32];
        end else begin : g_zext
            assign core32[k] = {{(32-CORE_W){1'b0}}, snap[k*CORE_W +: CORE_W]};
        end
    end

    always_comb begin
        beat_word = '0;
        for (int i = 0; i < BEATS; i++) begin
            if (beat_cnt == CNT_W'(i)) begin
                beat_word = {core32[2*i+1], core32[2*i]};
            end
        end
    end

    assign capture = res_valid && (state == IDLE);
    assign busy    = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            beat_cnt <= '0;
            snap     <= '0;
            dst_data <= '0;
            get_fin  <= 1'b0;
            err      <= 2'b00;
        end else begin
            get_fin <= capture;
            if (res_valid && (state != IDLE)) begin
                err[0] <= 1'b1;
            end
            if (stream_v && (state == IDLE)) begin
                err[1] <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (stream_v) begin
                        dst_data <= '0;
                    end
                    if (res_valid) begin
                        snap     <= res_data;
                        beat_cnt <= '0;
                        state    <= LOADED;
                    end
                end
                LOADED, STREAM: begin
                    // A result arriving here, even on the final beat, is dropped.
                    if (stream_v) begin
                        dst_data <= beat_word;
                        if (beat_cnt == LAST_BEAT) begin
                            beat_cnt <= '0;
                            state    <= IDLE;
                        end else begin
                            beat_cnt <= beat_cnt + CNT_W'(1);
                            state    <= STREAM;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_stream_pack.sv
// Scoreboard bench for stream_pack: a queue-of-beats reference model predicts
// every cycle's outputs; a separate monitor pops and compares them.
module tb_stream_pack;

    localparam int CORE_NUM = 4;
    localparam int CORE_W   = 32;
    localparam int BEATS    = CORE_NUM / 2;

    logic                       clk = 1'b0;
    logic                       rst = 1'b1;
    logic                       res_valid = 1'b0;
    logic [CORE_NUM*CORE_W-1:0] res_data = '0;
    logic                       stream_v = 1'b0;
    logic                       dst_ready = 1'b1;
    logic                       get_fin;
    logic [63:0]                dst_data;
    logic                       busy;
    logic [1:0]                 err;

    stream_pack #(.CORE_NUM(CORE_NUM), .CORE_W(CORE_W)) dut (
        .clk(clk), .rst(rst), .res_valid(res_valid), .res_data(res_data),
        .stream_v(stream_v), .dst_ready(dst_ready), .get_fin(get_fin),
        .dst_data(dst_data), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        fin;
        logic [63:0] dst;
        logic        bsy;
        logic [1:0]  er;
    } exp_t;

    exp_t        sb [$];
    logic [63:0] mq [$];
    logic [63:0] m_dst = '0;
    logic [1:0]  m_err = '0;
    logic        m_fin = 1'b0;
    int          n_chk = 0;
    int          n_err = 0;

    function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    // Reference: a held result set is just the list of beats still to send.
    task automatic model(input logic r, input logic rv, input logic [127:0] rd, input logic sv);
        logic held;
        if (r) begin
            mq.delete();
            m_dst = '0;
            m_err = '0;
            m_fin = 1'b0;
        end else begin
            held  = (mq.size() != 0);
            m_fin = rv && !held;
            if (sv) begin
                if (held) begin
                    m_dst = mq.pop_front();
                end else begin
                    m_dst = '0;
                    m_err[1] = 1'b1;
                end
            end
            if (rv) begin
                if (held) begin
                    m_err[0] = 1'b1;
                end else begin
                    for (int j = 0; j < BEATS; j++) begin
                        mq.push_back({rd[(2*j+1)*32 +: 32], rd[(2*j)*32 +: 32]});
                    end
                end
            end
        end
    endtask

    task automatic step(input logic r, input logic rv, input logic [127:0] rd,
                        input logic sv, input logic dr);
        exp_t e;
        @(negedge clk);
        rst = r; res_valid = rv; res_data = rd; stream_v = sv; dst_ready = dr;
        model(r, rv, rd, sv);
        e.fin = m_fin;
        e.dst = m_dst;
        e.bsy = (mq.size() != 0);
        e.er  = m_err;
        sb.push_back(e);
        @(posedge clk);
        #2;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("sb_get_fin", 64'(get_fin), 64'(e.fin));
                check("sb_dst_data", dst_data, e.dst);
                check("sb_busy", 64'(busy), 64'(e.bsy));
                check("sb_err", 64'(err), 64'(e.er));
            end
        end
    end

    localparam logic [127:0] D1 = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
    localparam logic [127:0] D2 = {32'hdddddddd, 32'hcccccccc, 32'hbbbbbbbb, 32'haaaaaaaa};

    initial begin : stim
        logic        rv, sv, dr, r;
        logic [127:0] rd;

        step(1, 0, '0, 0, 1);
        step(1, 0, '0, 0, 1);
        check("reset_dst", dst_data, 64'h0);
        check("reset_err", 64'(err), 64'h0);
        check("reset_busy", 64'(busy), 64'h0);

        // Basic load and two beats
        step(0, 1, D1, 0, 1);
        check("load_get_fin", 64'(get_fin), 64'h1);
        check("load_busy", 64'(busy), 64'h1);
        step(0, 0, '0, 1, 1);
        check("basic_beat0", dst_data, 64'h2222222211111111);
        check("basic_fin_once", 64'(get_fin), 64'h0);
        step(0, 0, '0, 1, 1);
        check("basic_beat1", dst_data, 64'h4444444433333333);
        check("basic_busy_fall", 64'(busy), 64'h0);

        // Stall between beats
        step(0, 1, D1, 0, 1);
        step(0, 0, '0, 1, 1);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, '0, 0, 0);
            check("stall_hold", dst_data, 64'h2222222211111111);
        end
        step(0, 0, '0, 1, 1);
        check("stall_beat1", dst_data, 64'h4444444433333333);

        // Overrun while LOADED
        step(0, 1, D1, 0, 1);
        step(0, 1, D2, 0, 1);
        check("overrun_err", 64'(err), 64'h1);
        check("overrun_no_fin", 64'(get_fin), 64'h0);
        step(0, 0, '0, 1, 1);
        check("overrun_beat0", dst_data, 64'h2222222211111111);
        step(0, 0, '0, 1, 1);
        check("overrun_beat1", dst_data, 64'h4444444433333333);
        step(1, 0, '0, 0, 1);

        // Underrun in IDLE
        step(0, 0, '0, 1, 1);
        check("underrun_dst", dst_data, 64'h0);
        check("underrun_err", 64'(err), 64'h2);
        check("underrun_busy", 64'(busy), 64'h0);
        step(1, 0, '0, 0, 1);

        // Reset mid-stream, then a fresh set
        step(0, 1, D1, 0, 1);
        step(0, 0, '0, 1, 1);
        step(1, 0, '0, 1, 1);
        step(0, 1, D2, 0, 1);
        step(0, 0, '0, 1, 1);
        check("rst_mid_beat0", dst_data, 64'hbbbbbbbbaaaaaaaa);
        step(0, 0, '0, 1, 1);
        check("rst_mid_beat1", dst_data, 64'hddddddddcccccccc);
        check("rst_mid_err", 64'(err), 64'h0);

        // Result coincident with final beat
        step(0, 1, D1, 0, 1);
        step(0, 0, '0, 1, 1);
        step(0, 1, D2, 1, 1);
        check("coinc_beat1", dst_data, 64'h4444444433333333);
        check("coinc_busy", 64'(busy), 64'h0);
        check("coinc_err0", 64'(err[0]), 64'h1);
        step(0, 0, '0, 0, 1);
        check("coinc_no_fin", 64'(get_fin), 64'h0);
        step(1, 0, '0, 0, 1);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            r  = ($urandom_range(0, 99) == 0);
            rv = ($urandom_range(0, 5) == 0);
            dr = ($urandom_range(0, 3) != 0);
            sv = dr && ($urandom_range(0, 1) == 1);
            rd = {$urandom(), $urandom(), $urandom(), $urandom()};
            step(r, rv, rd, sv, dr);
        end

        step(0, 0, '0, 0, 1);
        check("sb_drain", 64'(sb.size()), 64'h0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
